// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bit-cell constants for the I2C write master
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP} state_t;
    localparam logic [1:0] Q_SET    = 2'd0;
    localparam logic [1:0] Q_RISE   = 2'd1;
    localparam logic [1:0] Q_SAMPLE = 2'd2;
    localparam logic [1:0] Q_FALL   = 2'd3;
    localparam logic       RW_WRITE = 1'b0;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: one-cycle tick every CLK_DIV clocks, phase restartable
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    // the restart cycle itself counts as phase 0, so the first tick lands CLK_DIV-1 cycles later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= restart ? W'(1) : (tick ? '0 : cnt + 1'b1);
    end
endmodule

// File: rtl/i2c_master_tx.sv
// i2c_master_tx: I2C write master with byte-stream input, ACK check and open-drain SDA
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] data,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl,
    inout  wire        sda
);
    state_t state_q, state_d;
    logic [1:0] q_q, q_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sr_q, sr_d;
    logic last_q, last_d, ack_q, ack_d;
    logic scl_q, scl_d, sda_low_q, sda_low_d;
    logic nack_q, nack_d, done_q, done_d;
    logic tick, restart;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk), .rst(rst), .restart(restart), .tick(tick)
    );

    assign sda        = sda_low_q ? 1'b0 : 1'bz;
    assign scl        = scl_q;
    assign busy       = state_q != IDLE;
    assign data_ready = state_q == LOAD;
    assign done       = done_q;
    assign nack       = nack_q;

    // state and line registers; reset releases both lines at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            q_q       <= Q_SET;
            bit_q     <= 3'd7;
            sr_q      <= '0;
            last_q    <= 1'b0;
            ack_q     <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
            nack_q    <= nack_d;
            done_q    <= done_d;
        end
    end

    // frame sequencing: every line change happens on the tick that ends a quarter
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        last_d    = last_q;
        ack_d     = ack_q;
        scl_d     = scl_q;
        sda_low_d = sda_low_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        restart   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                restart = 1'b1;
                sr_d    = {dev_addr, RW_WRITE};
                nack_d  = 1'b0;
                q_d     = Q_SET;
                state_d = START;
            end
            START: if (tick) begin
                q_d = q_q + 2'd1;
                if (q_q == Q_SET) sda_low_d = 1'b1;
                if (q_q == Q_RISE) begin
                    scl_d   = 1'b0;
                    q_d     = Q_SET;
                    bit_d   = 3'd7;
                    state_d = ADDR;
                end
            end
            ADDR, DATA: if (tick) begin
                q_d = q_q + 2'd1;
                if (q_q == Q_SET) sda_low_d = ~sr_q[7];
                if (q_q == Q_RISE) scl_d = 1'b1;
                if (q_q == Q_FALL) begin
                    scl_d = 1'b0;
                    sr_d  = {sr_q[6:0], 1'b0};
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) begin
                        bit_d   = 3'd7;
                        state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                    end
                end
            end
            ADDR_ACK, DATA_ACK: if (tick) begin
                q_d = q_q + 2'd1;
                if (q_q == Q_SET) sda_low_d = 1'b0;
                if (q_q == Q_RISE) scl_d = 1'b1;
                if (q_q == Q_SAMPLE) ack_d = sda;
                if (q_q == Q_FALL) begin
                    scl_d   = 1'b0;
                    nack_d  = nack_q | ack_q;
                    state_d = (ack_q || (state_q == DATA_ACK && last_q)) ? STOP : LOAD;
                end
            end
            LOAD: if (data_valid) begin
                restart = 1'b1;
                sr_d    = data;
                last_d  = data_last;
                q_d     = Q_SET;
                bit_d   = 3'd7;
                state_d = DATA;
            end
            STOP: if (tick) begin
                q_d = q_q + 2'd1;
                if (q_q == Q_SET) sda_low_d = 1'b1;
                if (q_q == Q_RISE) scl_d = 1'b1;
                if (q_q == Q_SAMPLE) begin
                    sda_low_d = 1'b0;
                    done_d    = 1'b1;
                    q_d       = Q_SET;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/i2c_master_tx.md
# i2c_master_tx

Parametrised I2C write master. It is the next generation of the fixed-rate byte transmitter in the waveform generator's IIC path and drives DAC/PLL configuration devices. It adds:

- a programmable SCL rate;
- a proper START, 7-bit address, R/W=0 and STOP framing;
- multi-byte bursts through a valid/ready byte stream;
- ACK sampling with NACK abort;
- open-drain SDA.

It sits between the configuration sequencer (byte source) and the board I2C pins.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period Q. Must be ≥2. Bit time is 4·CLK_DIV clocks.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request. Accepted only in the cycle busy=0.
- dev_addr  in  7  slave address. Captured on start accept.
- data  in  8  payload byte, MSB first.
- data_valid  in  1  byte available.
- data_last  in  1  accepted byte is the final byte of the frame.
- data_ready  out  1  master can take a byte this cycle. Transfer happens when data_valid & data_ready.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame ends (normal or NACK).
- nack  out  1  sticky. Set on any NACK; cleared on next start accept.
- scl  out  1  SCL, push-pull.
- sda  inout  1  open-drain: drives 0 or z, never 1. Sampled through the pad.

## Operation
- Reset values: scl=1, sda=z, busy=0, done=0, nack=0, data_ready=0, state IDLE.
- States: IDLE → START → ADDR → ADDR_ACK → LOAD → DATA → DATA_ACK → (LOAD | STOP) → IDLE.
- IDLE: lines idle high. On start, capture {dev_addr,1'b0} into the shift register, clear nack, set busy.
- START: SDA driven low while SCL is high, then SCL low.
- ADDR / DATA: 8 bits MSB first, shift register left-shifted once per bit. A 3-bit bit counter goes 7→0 and reloads to 7 on entering the ACK phase.
- ADDR_ACK / DATA_ACK: SDA released; the slave's bit is sampled.
  - Sampled 0 (ACK): continue.
  - Sampled 1 (NACK): set nack, go to STOP. No further bytes are requested.
- LOAD: entered with SCL low.
  - data_ready is high in LOAD only.
  - On handshake: load data, latch data_last, go to DATA.
  - If data_valid is low, SCL is held low indefinitely. Master-side stretch, no timeout.
- After DATA_ACK: go to STOP if the latched last flag is set, else go to LOAD.
- STOP: SDA low, SCL high, then SDA released high. Then pulse done, clear busy, return to IDLE.
- start while busy=1: ignored, no effect on the current frame.
- data_valid outside LOAD: ignored; data_ready stays 0.
- Reset mid-frame: lines released immediately (scl=1, sda=z). No STOP is generated.

## Timing
- A divider produces a one-cycle tick every CLK_DIV clocks. Counter width is $clog2(CLK_DIV), and it wraps to 0 on tick. All line changes occur on ticks; the tick phase restarts on start accept.
- Bit cell, quarters q0..q3:
  - q0: SDA set, SCL low.
  - q1: SCL rises.
  - q2: SCL high; SDA sampled on the tick ending q2.
  - q3: SCL falls.
- SDA changes only while SCL is low, except the START and STOP edges.
- START = 2Q: SDA falls at end of Q0, SCL falls at end of Q1.
- STOP = 3Q: SDA low, SCL rises at end of Q1, SDA released at end of Q2.
- LOAD costs 0 quarters when data_valid is already high on entry. The handshake occurs in the LOAD entry cycle.
- Latency: with the accept cycle = 0 and data always valid, done is high in cycle (5+36·(N+1))·CLK_DIV for N data bytes.
  - busy rises in cycle 1.
  - busy falls in the same cycle done pulses.
- NACK on address: done at (5+36)·CLK_DIV. data_ready never asserts.

## Structure
- Package i2c_pkg holds:
  - the state enum (IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP);
  - quarter-index constants Q_SET=0, Q_RISE=1, Q_SAMPLE=2, Q_FALL=3;
  - the R/W write-bit constant.
- Sub-module i2c_quarter_tick: parametrised CLK_DIV divider with a synchronous phase-restart input and a tick output.
- Target size 200–300 lines.

## Test plan
- Reset mid-address (assert rst at cycle 50) → scl=1, sda=z, busy=0 within the same cycle. No done pulse.
- CLK_DIV=4, addr 7'h48, one byte 8'hA5 with last, slave ACKs all → SDA bits are 0x90 then 0xA5 on the SCL rising edges. done at cycle 308. nack=0.
- Addr 7'h50, slave NACKs address → nack=1, STOP generated, done at cycle 164, data_ready never high.
- Three bytes 8'h01, 8'h02, 8'h03 (last on third); slave NACKs the second data byte → third byte never accepted; STOP follows; nack=1.
- Two-byte frame, data_valid withheld 100 cycles in LOAD → SCL stays low 100 cycles. Then the frame resumes with correct bits and done timing shifted by exactly 100.
- start pulsed while busy → ignored, frame unchanged. The next start after done clears nack and starts a new frame with SDA falling at cycle CLK_DIV.
